paddle_input: RTL and testbench
===============================

Name: paddle_input

Overview:
- Input-conditioning stage directly upstream of the paddle block; it produces that block's moveLeft/moveRight.
- Synchronises and debounces the two raw pushbuttons and tracks held direction in a small FSM.
- Emits at most one single-cycle move pulse per frame tick, with a slow-start ramp: every other frame at first, then every frame.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive cycles a synced button must differ from its debounced level before the level flips (10 ms at 50 MHz); legal range ≥2.
- CNT_WIDTH, 19, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- SLOW_FRAMES, 8, frame ticks after a direction starts during which pulses occur only on every other tick.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- btnLeft, input, 1, raw left button, asynchronous to clk, active-high.
- btnRight, input, 1, raw right button, asynchronous to clk, active-high.
- frameTick, input, 1, one-cycle pulse once per video frame.
- enable, input, 1, 0 suppresses move pulses; all tracking continues.
- moveLeft, output, 1, one-cycle move-left pulse to the paddle.
- moveRight, output, 1, one-cycle move-right pulse to the paddle.
- leftHeld, output, 1, debounced left level.
- rightHeld, output, 1, debounced right level.

Behaviour:
- Reset (async, rst=1):
  - Sync flops, debounced levels, debounce counters, holdCnt, moveLeft and moveRight all go to 0.
  - FSM goes to IDLE.
  - All state is held there while rst=1.
  - Operation resumes on the first clk edge after rst deasserts.
- Synchroniser: two-flop chain per button. The synced value lags the raw input by 2 cycles.
- Debounce, per button, evaluated each cycle:
  - If synced == debounced: counter <= 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: debounced <= synced and counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to the debounced level clears the counter.
  - Total latency from a clean raw edge to the leftHeld/rightHeld change is 2+DEBOUNCE_CYCLES cycles.
- FSM: states IDLE, LEFT, RIGHT, BOTH. Next state from the debounced levels (L,R):
  - 00 → IDLE.
  - 10 → LEFT.
  - 01 → RIGHT.
  - 11 → BOTH.
  - Any change of state clears holdCnt to 0.
- Pulse decision, taken on a cycle with frameTick=1, using the current (pre-edge) state and holdCnt:
  - In LEFT or RIGHT with enable=1:
    - Pulse the matching output iff holdCnt ≥ SLOW_FRAMES or holdCnt[0]==0.
  - In LEFT or RIGHT regardless of enable:
    - holdCnt <= min(holdCnt+1, SLOW_FRAMES), saturating.
  - In IDLE or BOTH: no pulse; holdCnt stays 0.
- If a state change and frameTick coincide:
  - The pulse follows the old state.
  - holdCnt is cleared, since the clear takes priority over the increment.
- moveLeft/moveRight are registered.
  - Each is high for exactly the one cycle after the qualifying frameTick, otherwise 0.
  - They are never both high.
- enable=0: outputs forced 0. FSM, holdCnt and debounce keep running, so re-enabling mid-hold continues the ramp from the current holdCnt.
- frameTick held high on consecutive cycles: each high cycle is a separate tick. This is legal and not filtered.
- Pulse pattern for a continuous hold (ticks numbered from entry, holdCnt 0..), SLOW_FRAMES=8:
  - Pulses on ticks 0, 2, 4, 6.
  - Then on every tick from 8 onward.

Test Plan:
- Reset, single press:
  - Stimulus: DEBOUNCE_CYCLES=4. Assert rst mid-run with btnRight held, release rst, keep btnRight high.
  - Response: rightHeld rises exactly 6 cycles after the first post-reset edge. moveRight=0 until the first frameTick after that, then a 1-cycle pulse.
- Bounce rejection:
  - Stimulus: DEBOUNCE_CYCLES=4. btnLeft toggles high 3 cycles, low 1 cycle, repeated 5 times.
  - Response: leftHeld stays 0; no moveLeft pulses.
- Slow-start ramp:
  - Stimulus: SLOW_FRAMES=8. Hold right; apply 14 frameTicks.
  - Response: moveRight pulses on ticks 0, 2, 4, 6, 8, 9, 10, 11, 12, 13 (10 pulses).
- Both held:
  - Stimulus: hold right through 3 ticks, then add left.
  - Response: after leftHeld rises, no pulses. Releasing right enters LEFT with holdCnt=0; moveLeft pulses on the next tick.
- Enable gating:
  - Stimulus: hold left; enable=0 for ticks 0–9, enable=1 from tick 10.
  - Response: zero pulses during ticks 0–9. Pulses every tick from tick 10 (holdCnt already saturated at 8).
- Coincident transition:
  - Stimulus: left debounced-release lands on the same cycle as frameTick while in LEFT at holdCnt=8.
  - Response: one final moveLeft pulse; state becomes IDLE with holdCnt=0.

Source files
------------

// File: rtl/paddle_input_if.sv
// paddle_input_if
//   Groups the button/frame inputs and the paddle-facing outputs of
//   paddle_input, plus two debug views of its internal state.
//
//   Handshake: there is no valid/ready pair here. frameTick is a one-cycle
//   strobe qualified by nothing else, and moveLeft/moveRight are one-cycle
//   strobes the consumer must accept in the cycle they are high (no
//   back-pressure exists).
//
//   Signals:
//     btnLeft, btnRight  raw pushbuttons, asynchronous to clk, active-high
//     frameTick          one-cycle pulse per video frame
//     enable             0 suppresses move pulses, tracking continues
//     moveLeft/Right     registered one-cycle move pulses
//     leftHeld/rightHeld debounced button levels
//     dbgState           FSM state (0 IDLE, 1 LEFT, 2 RIGHT, 3 BOTH)
//     dbgHoldCnt         frame-tick hold counter, zero-extended to 8 bits
//
//   Modports: master drives the inputs (stimulus/upstream side),
//             slave is the paddle_input block itself.
interface paddle_input_if;
    logic       btnLeft;
    logic       btnRight;
    logic       frameTick;
    logic       enable;
    logic       moveLeft;
    logic       moveRight;
    logic       leftHeld;
    logic       rightHeld;
    logic [1:0] dbgState;
    logic [7:0] dbgHoldCnt;

    modport master (
        output btnLeft, btnRight, frameTick, enable,
        input  moveLeft, moveRight, leftHeld, rightHeld, dbgState, dbgHoldCnt
    );

    modport slave (
        input  btnLeft, btnRight, frameTick, enable,
        output moveLeft, moveRight, leftHeld, rightHeld, dbgState, dbgHoldCnt
    );
endinterface

// File: rtl/paddle_input.sv
// paddle_input
//   Input-conditioning stage in front of the paddle block. Each raw button
//   goes through a two-flop synchroniser and a counter debouncer; the two
//   debounced levels drive a four-state direction FSM. On every frameTick
//   while exactly one direction is held, a single-cycle move pulse is
//   emitted, with a slow-start ramp: for the first SLOW_FRAMES ticks only
//   every other tick pulses, after that every tick does.
//
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset
//     io   paddle_input_if.slave (buttons, frameTick, enable in;
//          moveLeft/moveRight, leftHeld/rightHeld, debug state out)
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles a synced button must disagree with its
//                      debounced level before the level flips (>= 2)
//     CNT_WIDTH        debounce counter width, must hold DEBOUNCE_CYCLES-1
//     SLOW_FRAMES      ticks of half-rate pulsing after a direction starts
//                      (<= 255 so the debug view can show it)
module paddle_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 19,
    parameter int SLOW_FRAMES     = 8
) (
    input  logic           clk,
    input  logic           rst,
    paddle_input_if.slave  io
);

    localparam int HOLD_W = $clog2(SLOW_FRAMES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(SLOW_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        BOTH  = 2'd3
    } state_t;

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0]           syncStage1;
    logic [1:0]           syncStage2;
    logic [1:0]           held;
    logic [CNT_WIDTH-1:0] dbCnt [2];

    state_t               state;
    state_t               nextState;
    logic [HOLD_W-1:0]    holdCnt;

    logic                 pulseLeft;
    logic                 pulseRight;
    logic                 holdAdvance;
    logic                 rampOpen;
    logic                 moveLeftQ;
    logic                 moveRightQ;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer. A counter only advances while the synced
    // value disagrees with the debounced level, so any bounce back to the
    // current level restarts the whole qualification window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
            held       <= '0;
            dbCnt[0]   <= '0;
            dbCnt[1]   <= '0;
        end else begin
            syncStage1 <= {io.btnRight, io.btnLeft};
            syncStage2 <= syncStage1;
            for (int i = 0; i < 2; i++) begin
                if (syncStage2[i] == held[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == CNT_LAST) begin
                    held[i]  <= syncStage2[i];
                    dbCnt[i] <= '0;
                end else begin
                    dbCnt[i] <= dbCnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Direction FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state is a direct decode of the debounced levels.
    always_comb begin
        nextState = IDLE;
        case (held)
            2'b00:   nextState = IDLE;
            2'b01:   nextState = LEFT;
            2'b10:   nextState = RIGHT;
            default: nextState = BOTH;
        endcase
    end

    // Output decode: the pulse decision looks at the pre-edge state and
    // holdCnt, so a tick coinciding with a state change still pulses for
    // the direction being left.
    always_comb begin
        pulseLeft   = 1'b0;
        pulseRight  = 1'b0;
        holdAdvance = 1'b0;
        // Even hold counts pulse during the ramp; once saturated every tick does.
        rampOpen    = (holdCnt >= HOLD_MAX) || !holdCnt[0];
        if (io.frameTick) begin
            case (state)
                LEFT: begin
                    holdAdvance = 1'b1;
                    pulseLeft   = io.enable && rampOpen;
                end
                RIGHT: begin
                    holdAdvance = 1'b1;
                    pulseRight  = io.enable && rampOpen;
                end
                default: begin
                    holdAdvance = 1'b0;
                end
            endcase
        end
    end

    // Hold counter: a state change clears it and wins over an increment on
    // the same cycle; otherwise it counts ticks up to SLOW_FRAMES and sticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdCnt <= '0;
        end else if (nextState != state) begin
            holdCnt <= '0;
        end else if (holdAdvance && (holdCnt != HOLD_MAX)) begin
            holdCnt <= holdCnt + HOLD_W'(1);
        end
    end

    // Registered move pulses; LEFT and RIGHT are exclusive states, so the
    // two pulses can never be high together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            moveLeftQ  <= 1'b0;
            moveRightQ <= 1'b0;
        end else begin
            moveLeftQ  <= pulseLeft;
            moveRightQ <= pulseRight;
        end
    end

    assign io.moveLeft   = moveLeftQ;
    assign io.moveRight  = moveRightQ;
    assign io.leftHeld   = held[0];
    assign io.rightHeld  = held[1];
    assign io.dbgState   = state;
    assign io.dbgHoldCnt = 8'(holdCnt);

endmodule

// File: tb/tb_paddle_input.sv
// tb_paddle_input
//   Self-checking bench for paddle_input with DEBOUNCE_CYCLES=4,
//   CNT_WIDTH=2, SLOW_FRAMES=8. Every cycle driven through runCycle pushes
//   the expected {moveLeft, moveRight} onto exp_q; the value is popped and
//   compared once the DUT has registered its output for that edge.
module tb_paddle_input;

    localparam int DEB    = 4;
    localparam int CW     = 2;
    localparam int SLOW   = 8;
    localparam int SETTLE = DEB + 4;  // raw edge -> held (2+DEB) -> state (+1), plus margin

    localparam int S_IDLE  = 0;
    localparam int S_LEFT  = 1;
    localparam int S_RIGHT = 2;
    localparam int S_BOTH  = 3;

    typedef struct {
        logic en;
        logic expL;
        logic expR;
    } vec_t;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    paddle_input_if io();

    paddle_input #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (CW),
        .SLOW_FRAMES    (SLOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int         nVec = 0;
    int         nMis = 0;
    logic [1:0] exp_q[$];
    vec_t       rampTbl[14];
    vec_t       enTbl[14];
    int         pulseCount;

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic scoreboardPop(input string name);
        logic [1:0] e;
        logic [1:0] got;
        got = {io.moveLeft, io.moveRight};
        if (exp_q.size() == 0) begin
            nVec++;
            nMis++;
            $display("FAIL %s: scoreboard empty, got move=%b", name, got);
        end else begin
            e = exp_q.pop_front();
            check(name, int'(got), int'(e));
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks. Inputs change and outputs are sampled 1 ns after the
    // rising edge.
    // ------------------------------------------------------------------
    task automatic runCycle(input logic ft, input logic expL, input logic expR);
        io.frameTick = ft;
        exp_q.push_back({expL, expR});
        @(posedge clk);
        #1;
        io.frameTick = 1'b0;
        scoreboardPop(ft ? "move_on_tick" : "move_quiet");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) runCycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkState(input string name, input int st, input int hc);
        check({name, "_state"}, int'(io.dbgState), st);
        check({name, "_holdCnt"}, int'(io.dbgHoldCnt), hc);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        // Vector tables: slow-start ramp with right held, then enable gating
        // with left held (disabled for ticks 0-9, enabled from tick 10).
        for (int i = 0; i < 14; i++) begin
            rampTbl[i].en   = 1'b1;
            rampTbl[i].expL = 1'b0;
            rampTbl[i].expR = (i >= SLOW) || ((i % 2) == 0);
            enTbl[i].en     = (i >= 10);
            enTbl[i].expL   = (i >= 10);
            enTbl[i].expR   = 1'b0;
        end

        io.btnLeft   = 1'b0;
        io.btnRight  = 1'b0;
        io.frameTick = 1'b0;
        io.enable    = 1'b1;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_moveLeft", int'(io.moveLeft), 0);
        check("reset_moveRight", int'(io.moveRight), 0);
        check("reset_held", int'({io.leftHeld, io.rightHeld}), 0);
        checkState("reset", S_IDLE, 0);
        rst = 1'b0;

        // Get into RIGHT, then assert reset mid-run with the button still held.
        io.btnRight = 1'b1;
        idle(SETTLE);
        check("prerun_rightHeld", int'(io.rightHeld), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rightHeld", int'(io.rightHeld), 0);
        checkState("async_reset", S_IDLE, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_rightHeld", int'(io.rightHeld), 0);
        rst = 1'b0;

        // rightHeld must rise on exactly the 6th edge after reset release.
        for (int k = 1; k <= 7; k++) begin
            runCycle(1'b0, 1'b0, 1'b0);
            check("press_latency_rightHeld", int'(io.rightHeld), int'(k >= 2 + DEB));
        end
        checkState("press_entered", S_RIGHT, 0);
        runCycle(1'b1, 1'b0, 1'b1);
        runCycle(1'b0, 1'b0, 1'b0);

        io.btnRight = 1'b0;
        idle(SETTLE);
        checkState("release_right", S_IDLE, 0);

        // Bounce rejection: high 3 cycles, low 1 cycle (with a tick), x5.
        for (int r = 0; r < 5; r++) begin
            io.btnLeft = 1'b1;
            idle(3);
            io.btnLeft = 1'b0;
            runCycle(1'b1, 1'b0, 1'b0);
            check("bounce_leftHeld", int'(io.leftHeld), 0);
        end
        idle(SETTLE);
        check("bounce_final_leftHeld", int'(io.leftHeld), 0);
        checkState("bounce_final", S_IDLE, 0);

        // Slow-start ramp, random gaps (gap 0 gives back-to-back ticks).
        io.btnRight = 1'b1;
        idle(SETTLE);
        checkState("ramp_start", S_RIGHT, 0);
        pulseCount = 0;
        for (int i = 0; i < 14; i++) begin
            idle($urandom_range(0, 2));
            io.enable = rampTbl[i].en;
            runCycle(1'b1, rampTbl[i].expL, rampTbl[i].expR);
            if (io.moveRight) pulseCount++;
        end
        check("ramp_pulse_count", pulseCount, 10);
        checkState("ramp_end", S_RIGHT, SLOW);

        // Both held: fresh right hold, 3 ticks, then add left.
        io.btnRight = 1'b0;
        idle(SETTLE);
        io.btnRight = 1'b1;
        idle(SETTLE);
        runCycle(1'b1, 1'b0, 1'b1);
        runCycle(1'b1, 1'b0, 1'b0);
        runCycle(1'b1, 1'b0, 1'b1);
        io.btnLeft = 1'b1;
        idle(SETTLE);
        check("both_leftHeld", int'(io.leftHeld), 1);
        checkState("both", S_BOTH, 0);
        for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, 1'b0);
        checkState("both_after_ticks", S_BOTH, 0);
        io.btnRight = 1'b0;
        idle(SETTLE);
        checkState("both_to_left", S_LEFT, 0);
        runCycle(1'b1, 1'b1, 1'b0);

        // Enable gating: ramp keeps running while disabled.
        io.btnLeft = 1'b0;
        idle(SETTLE);
        io.enable  = 1'b0;
        io.btnLeft = 1'b1;
        idle(SETTLE);
        checkState("gate_start", S_LEFT, 0);
        for (int i = 0; i < 14; i++) begin
            io.enable = enTbl[i].en;
            if (i == 10) checkState("gate_reenable", S_LEFT, SLOW);
            runCycle(1'b1, enTbl[i].expL, enTbl[i].expR);
        end

        // Coincident transition: release lands on held after 6 edges; the
        // tick on the following edge sees old state LEFT at holdCnt=8.
        io.btnLeft = 1'b0;
        idle(2 + DEB);
        check("coincide_leftHeld", int'(io.leftHeld), 0);
        checkState("coincide_pre", S_LEFT, SLOW);
        runCycle(1'b1, 1'b1, 1'b0);
        checkState("coincide_post", S_IDLE, 0);
        runCycle(1'b0, 1'b0, 1'b0);
        runCycle(1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
